// File: rtl/ctrl_seq_unit.sv
// ctrl_seq_unit -- CPU control sequencer.
// Decodes the current instruction and stored ALU flags into the datapath
// strobes: register, ALU, IP/DP swap and memory. Memory cycles wait on mem_rdy.
// Optional feature macro: CTRL_SEQ_WAIT_TIMEOUT_EN. When it is defined, a
// memory access that stalls for MAX_WAIT cycles raises a sticky bus_err and
// parks the sequencer in HALT. Without the macro, waits are unbounded and
// bus_err is tied low.
module ctrl_seq_unit #(
   parameter int IR_W     = 8,
   parameter int SEL_W    = 2,
   parameter int MAX_WAIT = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IR_W-1:0]         ir,
   input  logic [(2**SEL_W)-1:0]   flags,
   input  logic                    mem_rdy,
   output logic                    oe_mem,
   output logic                    we_mem,
   output logic                    we_ir,
   output logic                    inc_ip,
   output logic                    addr_dp,
   output logic                    p_selector,
   output logic [(2**SEL_W)-1:0]   we_reg,
   output logic [(2**SEL_W)-1:0]   oe_reg_alu,
   output logic [(2**SEL_W)-1:0]   oe_reg_d,
   output logic                    oe_alu_di,
   output logic                    we_flags,
   output logic                    bus_err
);

   localparam int NREGS = 2**SEL_W;
   localparam int T     = IR_W - 1;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_IMM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Reject parameter sets that the instruction layout cannot hold.
   if (IR_W < SEL_W + 6) begin : g_bad_ir_w
      $error("ctrl_seq_unit: IR_W must be >= SEL_W+6");
   end
   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("ctrl_seq_unit: MAX_WAIT must be >= 1");
   end

   // One-hot select of a register or flag index.
   function automatic logic [NREGS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NREGS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_psel;
   logic              w_psel_tgl;
   logic              w_timeout;

   // Instruction decode.
   logic              w_is_alu;
   logic              w_is_jmp;
   logic              w_is_ldi;
   logic              w_is_st;
   logic              w_is_ld;
   logic [3:0]        w_op;
   logic              w_dir;
   logic              w_uncond;
   logic              w_invert;
   logic [SEL_W-1:0]  w_idx;
   logic              w_take;

   assign w_is_alu = ~ir[T];
   assign w_is_jmp = ir[T] &  ir[T-1];
   assign w_is_ldi = ir[T] & ~ir[T-1] &  ir[T-2];
   assign w_is_st  = ir[T] & ~ir[T-1] & ~ir[T-2] &  ir[T-3];
   assign w_is_ld  = ir[T] & ~ir[T-1] & ~ir[T-2] & ~ir[T-3];
   assign w_op     = ir[T-1:T-4];
   assign w_dir    = ir[SEL_W];
   assign w_invert = ir[SEL_W];
   assign w_uncond = ir[SEL_W+1];
   assign w_idx    = ir[SEL_W-1:0];
   assign w_take   = w_uncond | (flags[w_idx] ^ w_invert);

`ifdef CTRL_SEQ_WAIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic              w_access;
   logic              w_stall;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_bus_err;

   // A cycle is an access whenever the bus is being used for memory.
   assign w_access = (r_state == S_FETCH) || (r_state == S_IMM) ||
                     ((r_state == S_EXEC) && (w_is_ld || w_is_st));
   assign w_stall   = w_access & ~mem_rdy;
   assign w_timeout = w_stall && (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

   // Stall counter: counts stalled cycles; any non-stalled cycle clears it,
   // so every new access starts from zero. bus_err is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         if (w_stall && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end else begin
            r_bus_err <= r_bus_err;
         end
      end
   end

   assign bus_err = r_bus_err;
`else
   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   // State register and IP/DP swap flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_psel  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_psel_tgl) begin
            r_psel <= ~r_psel;
         end else begin
            r_psel <= r_psel;
         end
      end
   end

   assign p_selector = r_psel;

   // Next-state and strobe decode; every strobe is held low during reset.
   always_comb begin
      oe_mem      = 1'b0;
      we_mem      = 1'b0;
      we_ir       = 1'b0;
      inc_ip      = 1'b0;
      addr_dp     = 1'b0;
      we_reg      = '0;
      oe_reg_alu  = '0;
      oe_reg_d    = '0;
      oe_alu_di   = 1'b0;
      we_flags    = 1'b0;
      w_psel_tgl  = 1'b0;
      w_state_nxt = r_state;
      if (rst) begin
         w_state_nxt = S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: begin
               oe_mem  = 1'b1;
               addr_dp = 1'b0;
               if (mem_rdy) begin
                  we_ir       = 1'b1;
                  inc_ip      = 1'b1;
                  w_state_nxt = S_EXEC;
               end else if (w_timeout) begin
                  w_state_nxt = S_HALT;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
            S_EXEC: begin
               if (w_is_alu) begin
                  oe_reg_alu = onehot(w_idx);
                  oe_alu_di  = 1'b1;
                  if (w_dir) begin
                     we_reg = onehot(w_idx);
                  end else begin
                     we_reg = onehot('0);
                  end
                  if (w_op == 4'b1000) begin
                     we_flags = 1'b0;
                  end else begin
                     we_flags = 1'b1;
                  end
                  w_state_nxt = S_FETCH;
               end else if (w_is_jmp) begin
                  w_psel_tgl  = w_take;
                  w_state_nxt = S_FETCH;
               end else if (w_is_ldi) begin
                  w_state_nxt = S_IMM;
               end else if (w_is_st) begin
                  addr_dp  = 1'b1;
                  oe_reg_d = onehot(w_idx);
                  we_mem   = 1'b1;
                  if (mem_rdy) begin
                     w_state_nxt = S_FETCH;
                  end else if (w_timeout) begin
                     w_state_nxt = S_HALT;
                  end else begin
                     w_state_nxt = S_EXEC;
                  end
               end else begin
                  addr_dp = 1'b1;
                  oe_mem  = 1'b1;
                  if (mem_rdy) begin
                     we_reg      = onehot(w_idx);
                     w_state_nxt = S_FETCH;
                  end else if (w_timeout) begin
                     w_state_nxt = S_HALT;
                  end else begin
                     w_state_nxt = S_EXEC;
                  end
               end
            end
            S_IMM: begin
               oe_mem  = 1'b1;
               addr_dp = 1'b0;
               if (mem_rdy) begin
                  we_reg      = onehot(w_idx);
                  inc_ip      = 1'b1;
                  w_state_nxt = S_FETCH;
               end else if (w_timeout) begin
                  w_state_nxt = S_HALT;
               end else begin
                  w_state_nxt = S_IMM;
               end
            end
            S_HALT: begin
               w_state_nxt = S_HALT;
            end
            default: begin
               w_state_nxt = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
- Parametrised next-generation CPU control sequencer.
- Drives every register, ALU, pointer-swap and memory strobe from the current instruction and stored ALU flags.
- Adds memory wait states (mem_rdy handshake), register/flag banks scalable with SEL_W, and a sticky bus-error halt.
- Sits between the IR/flags registers and the datapath, replacing the fixed two-cycle controller.

Parameters:
- IR_W, 8, instruction width. Must be >= SEL_W+6.
- SEL_W, 2, register/flag index width. NREGS = NFLAGS = 2**SEL_W.
- MAX_WAIT, 7, stalled cycles allowed per memory access before bus error. Must be >= 1.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir  in  IR_W  current instruction. Valid outside FETCH.
- flags  in  2**SEL_W  stored ALU flags.
- mem_rdy  in  1  memory completes the current access this cycle.
- oe_mem  out  1  memory read enable.
- we_mem  out  1  memory write enable.
- we_ir  out  1  IR latches data bus at the cycle-ending edge.
- inc_ip  out  1  IP increments at the cycle-ending edge.
- addr_dp  out  1  0 = address from IP, 1 = address from DP.
- p_selector  out  1  IP/DP swap state, registered.
- we_reg  out  2**SEL_W  one-hot register write enable.
- oe_reg_alu  out  2**SEL_W  one-hot register onto ALU B input.
- oe_reg_d  out  2**SEL_W  one-hot register onto data bus.
- oe_alu_di  out  1  ALU result onto internal bus.
- we_flags  out  1  flags latch.
- bus_err  out  1  sticky wait-timeout indication.

Behaviour:
- Decode (T = IR_W-1):
  - ir[T]=0: ALU. Op field is ir[T-1:T-4]; dir = ir[SEL_W]; idx = ir[SEL_W-1:0].
  - ir[T]=1, ir[T-1]=1: jump. Unconditional bit = ir[SEL_W+1]; invert bit = ir[SEL_W].
  - ir[T]=1, ir[T-1]=0, ir[T-2]=1: LDI. The sto bit is ignored.
  - Otherwise ir[T-3]=1 is ST and ir[T-3]=0 is LD.
- States: FETCH, EXEC, IMM, HALT. Registers: p_selector, bus_err, wait_cnt (clog2(MAX_WAIT+1) bits). Strobes are combinational from state, ir and mem_rdy.
- Reset: asynchronous. Gives state=FETCH, wait_cnt=0, p_selector=0, bus_err=0. All outputs are 0 while rst=1. Reset mid-access abandons the access with no write.
- FETCH:
  - Drives oe_mem=1, addr_dp=0.
  - When mem_rdy=1: we_ir=1, inc_ip=1, next state EXEC.
  - When mem_rdy=0: state holds.
- EXEC, ALU (1 cycle):
  - oe_reg_alu = onehot(idx); oe_alu_di=1.
  - we_reg = onehot(0) if dir=0, else onehot(idx).
  - we_flags=1 unless op = 4'b1000 (MOV).
  - Next state FETCH.
- EXEC, LD: addr_dp=1, oe_mem=1. we_reg=onehot(idx) only when mem_rdy=1, then next state FETCH.
- EXEC, ST:
  - addr_dp=1, oe_reg_d=onehot(idx), we_mem=1, oe_mem=0 for the whole access.
  - The write commits at the edge where mem_rdy=1, then next state FETCH.
- EXEC, LDI: no strobes. Next state IMM.
- IMM:
  - addr_dp=0, oe_mem=1.
  - When mem_rdy=1: we_reg=onehot(idx), inc_ip=1, next state FETCH.
- EXEC, jump (1 cycle):
  - cond = flags[idx] XOR invert.
  - If uncond OR cond, p_selector toggles at the cycle-ending edge.
  - Next state FETCH.
- Wait states:
  - inc_ip, we_ir and we_reg stay 0 while mem_rdy=0.
  - wait_cnt clears on entry to every access state.
  - wait_cnt increments on each stalled cycle.
- HALT: all strobes 0, p_selector frozen. Left only by rst.
- Boundary: mem_rdy=1 on the first access cycle gives zero wait states. mem_rdy is ignored in non-memory cycles.

Optional Feature:
- Macro: CTRL_SEQ_WAIT_TIMEOUT_EN.
- Defined: a stalled cycle with wait_cnt == MAX_WAIT-1 sets bus_err=1 and moves to HALT; no write occurs. mem_rdy=1 arriving in that same cycle wins and completes normally.
- Undefined: waits are unbounded, bus_err is tied 0, HALT is unreachable, no wait_cnt is built.

Test Plan:
- Reset, then release rst with mem_rdy=1 -> first cycle oe_mem=1, we_ir=1, inc_ip=1, addr_dp=0, p_selector=0, bus_err=0. Assert rst in the EXEC of ST 0x93 -> we_mem drops to 0 immediately and FETCH follows.
- ir=0x45 (MOV, dir=1, idx=1) -> EXEC: we_reg=0010, oe_reg_alu=0010, we_flags=0. ir=0x0B (ADD, dir=0, idx=3) -> we_reg=0001, oe_reg_alu=1000, we_flags=1.
- LD ir=0x82, mem_rdy=0 for 2 cycles then 1 -> EXEC lasts 3 cycles with addr_dp=1, oe_mem=1; we_reg=0100 only in the third cycle; inc_ip=0 throughout.
- LDI ir=0xA1 with mem_rdy=1 -> FETCH, EXEC, IMM, FETCH; IMM has we_reg=0010, inc_ip=1, addr_dp=0.
- Jump 0xC1 with flags=0010 -> p_selector 0->1. Same with flags=0000 -> no change. 0xC5 with flags=0000 -> toggles. 0xC8 -> always toggles.
- With CTRL_SEQ_WAIT_TIMEOUT_EN and MAX_WAIT=3: LD with mem_rdy stuck 0 -> bus_err=1 after the 3rd stalled edge, all strobes 0 thereafter; rst clears it. Without the macro, the same stimulus stalls in EXEC indefinitely with bus_err=0.
